sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter NUM_CH, default 16, number of switch channels (1..32).
REQ-002 Parameter DEB_CYCLES, default 1000, consecutive stable cycles before a level is accepted (>=2).
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth (>=2).
REQ-004 Parameter RESET_VAL, default all-zero, NUM_CH-bit reset level of debounced outputs.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 sw_i  input  NUM_CH  raw asynchronous switch levels.
REQ-008 sw_stable_o  output  NUM_CH  debounced switch levels.
REQ-009 evt_valid_o  output  1  change event available.
REQ-010 evt_ready_i  input  1  consumer accepts event.
REQ-011 evt_ch_o  output  $clog2(NUM_CH) (min 1)  channel index of event.
REQ-012 evt_level_o  output  1  new debounced level of that channel.
REQ-013 ovf_o  output  NUM_CH  sticky per-channel lost-event flag.
REQ-014 ovf_clr_i  input  1  single-cycle pulse clearing all ovf_o bits.

Function
REQ-015 Each sw_i bit SHALL pass an independent SYNC_STAGES flop chain; only the last stage feeds the debouncer.
REQ-016 Per channel, FSM states SHALL be STABLE and COUNTING with a counter of $clog2(DEB_CYCLES) bits.
REQ-017 STABLE: synced != sw_stable_o -> COUNTING, counter=1; else stay.
REQ-018 COUNTING: synced == sw_stable_o -> STABLE, counter=0, no event (glitch rejected).
REQ-019 COUNTING: counter == DEB_CYCLES-1 and synced still differs -> sw_stable_o bit toggles, pending bit set, STABLE.
REQ-020 Otherwise COUNTING: counter increments; counter SHALL never wrap.
REQ-021 Latency: a clean sw_i edge SHALL appear on sw_stable_o exactly SYNC_STAGES+DEB_CYCLES clocks after the first sampling edge.
REQ-022 Output register SHALL load when evt_valid_o==0 or (evt_valid_o && evt_ready_i), from the lowest-index pending channel; that pending bit clears on load.
REQ-023 evt_valid_o, evt_ch_o, evt_level_o SHALL remain stable while evt_valid_o && !evt_ready_i.
REQ-024 Back-to-back acceptance SHALL sustain one event per clock when pending bits exist.
REQ-025 New stable change on a channel whose pending bit is already set SHALL set that ovf_o bit; pending stays set and the event reports the latest level.
REQ-026 ovf_clr_i coincident with a new overflow SHALL leave that bit set (set wins).
REQ-027 evt_valid_o SHALL drop to 0 after acceptance when no pending bits remain.

Reset
REQ-028 reset_i asserted SHALL immediately force: sync chains and sw_stable_o to RESET_VAL, all FSMs STABLE, counters 0, pending 0, evt_valid_o 0, evt_ch_o 0, evt_level_o 0, ovf_o 0.
REQ-029 Reset mid-COUNTING or with an un-accepted event SHALL discard it; no event emitted after release for pre-reset activity.
REQ-030 Reset deassertion SHALL be synchronised externally; block assumes release is clk-aligned.

Configuration
REQ-031 Macro SW_DEBOUNCE_TIMESTAMP_EN defined: free-running 32-bit cycle counter (reset 0, wraps 0xFFFFFFFF->0) and output evt_ts_o[31:0] holding the counter value at the cycle the pending bit was set, stored per channel and held with the event.
REQ-032 Macro undefined: no counter, no evt_ts_o port, no timestamp storage.

Structure
REQ-033 Package sw_debounce_pkg SHALL hold the FSM state enum, the MAX_CH=32 limit and the timestamp width constant.
REQ-034 Sub-module sw_debounce_ch SHALL implement one channel (sync chain, FSM, counter) and be generated NUM_CH times; arbitration and event register live in sw_debounce.

Verification
REQ-035 NUM_CH=4, DEB_CYCLES=8: sw_i[2] 0->1 held -> sw_stable_o[2]=1 exactly 10 clocks later; one event ch=2 level=1.
REQ-036 sw_i[0] pulse of 5 clocks -> no sw_stable_o change, no event.
REQ-037 sw_i[3:0] 0->0xF same cycle, evt_ready_i=1 -> four events ch 0,1,2,3 on consecutive clocks.
REQ-038 evt_ready_i=0, ch1 toggles 0->1->0 (each held 20 clocks) -> ovf_o[1]=1, single pending event level=0; ovf_clr_i -> ovf_o=0.
REQ-039 reset_i asserted at counter=5 -> outputs RESET_VAL/0 immediately; no event after release.
REQ-040 With SW_DEBOUNCE_TIMESTAMP_EN: ch2 event accepted late -> evt_ts_o equals cycle count at pending set, not at acceptance.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and limits for the switch debouncer.
package sw_debounce_pkg;

   localparam int MAX_CH = 32;
   localparam int TS_W   = 32;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } deb_state_t;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: synchroniser chain, debounce FSM and stability counter.
// chg pulses in the cycle whose rising edge commits a new stable level.
module sw_debounce_ch
   import sw_debounce_pkg::*;
#(
   parameter int   DEB_CYCLES  = 1000,
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic stable,
   output logic chg
);

   localparam int CNT_W = $clog2(DEB_CYCLES);

   logic [SYNC_STAGES-1:0] sync;
   logic                   synced;
   deb_state_t             state;
   logic [CNT_W-1:0]       cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= {SYNC_STAGES{RESET_VAL}};
      else     sync <= {sync[SYNC_STAGES-2:0], sw};
   end

   assign synced = sync[SYNC_STAGES-1];
   assign chg    = (state == ST_COUNTING) && (synced != stable) &&
                   (cnt == CNT_W'(DEB_CYCLES - 1));

   // The terminal count commits the level, so the counter never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_STABLE;
         cnt    <= '0;
         stable <= RESET_VAL;
      end else begin
         case (state)
            ST_STABLE: begin
               if (synced != stable) begin
                  state <= ST_COUNTING;
                  cnt   <= CNT_W'(1);
               end
            end
            ST_COUNTING: begin
               if (synced == stable) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                  stable <= ~stable;
                  state  <= ST_STABLE;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer with a valid/ready change-event port and sticky lost-event flags.
// Optional SW_DEBOUNCE_TIMESTAMP_EN adds a free-running cycle counter and evt_ts_o per event.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int                NUM_CH      = 16,
   parameter int                DEB_CYCLES  = 1000,
   parameter int                SYNC_STAGES = 2,
   parameter logic [NUM_CH-1:0] RESET_VAL   = '0,
   localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic [NUM_CH-1:0] sw_i,
   output logic [NUM_CH-1:0] sw_stable_o,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [CH_W-1:0]   evt_ch_o,
   output logic              evt_level_o,
   output logic [NUM_CH-1:0] ovf_o,
   input  logic              ovf_clr_i
`ifdef SW_DEBOUNCE_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]   evt_ts_o
`endif
);

   logic [NUM_CH-1:0] chg;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] load_mask;
   logic              sel_vld;
   logic [CH_W-1:0]   sel_ch;
   logic              load;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sw_debounce_ch #(
         .DEB_CYCLES  (DEB_CYCLES),
         .SYNC_STAGES (SYNC_STAGES),
         .RESET_VAL   (RESET_VAL[c])
      ) u_ch (
         .clk    (clk),
         .rst    (reset_i),
         .sw     (sw_i[c]),
         .stable (sw_stable_o[c]),
         .chg    (chg[c])
      );
   end

   // Fixed priority: lowest-index pending channel wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_ch  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_vld = 1'b1;
            sel_ch  = CH_W'(i);
         end
      end
   end

   assign load      = sel_vld && (!evt_valid_o || evt_ready_i);
   assign load_mask = load ? (NUM_CH'(1) << sel_ch) : '0;

   // A change landing while the same channel's pending bit is being loaded is a
   // fresh event, not a lost one; the level is read at load time so it is the latest.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         pending     <= '0;
         ovf_o       <= '0;
         evt_valid_o <= 1'b0;
         evt_ch_o    <= '0;
         evt_level_o <= 1'b0;
      end else begin
         pending <= (pending & ~load_mask) | chg;
         ovf_o   <= (ovf_o & ~{NUM_CH{ovf_clr_i}}) | (chg & pending & ~load_mask);
         if (!evt_valid_o || evt_ready_i) begin
            evt_valid_o <= sel_vld;
            if (sel_vld) begin
               evt_ch_o    <= sel_ch;
               evt_level_o <= sw_stable_o[sel_ch];
            end
         end
      end
   end

`ifdef SW_DEBOUNCE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] ts_mem [NUM_CH];

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         ts_cnt   <= '0;
         evt_ts_o <= '0;
         for (int i = 0; i < NUM_CH; i++) ts_mem[i] <= '0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         for (int i = 0; i < NUM_CH; i++) begin
            if (chg[i]) ts_mem[i] <= ts_cnt;
         end
         if (load) evt_ts_o <= ts_mem[sel_ch];
      end
   end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (4 channels, 8-cycle debounce, 2-stage sync).
module tb_sw_debounce;

   localparam int NCH  = 4;
   localparam int DEB  = 8;
   localparam int SYNC = 2;

   logic           clk = 1'b0;
   logic           reset_i;
   logic [NCH-1:0] sw_i;
   logic [NCH-1:0] sw_stable_o;
   logic           evt_valid_o;
   logic           evt_ready_i;
   logic [1:0]     evt_ch_o;
   logic           evt_level_o;
   logic [NCH-1:0] ovf_o;
   logic           ovf_clr_i;
`ifdef SW_DEBOUNCE_TIMESTAMP_EN
   logic [31:0]    evt_ts_o;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [1:0] ch;
      logic       lvl;
   } ev_t;

   sw_debounce #(
      .NUM_CH      (NCH),
      .DEB_CYCLES  (DEB),
      .SYNC_STAGES (SYNC),
      .RESET_VAL   (4'b0000)
   ) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .sw_i        (sw_i),
      .sw_stable_o (sw_stable_o),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_ch_o    (evt_ch_o),
      .evt_level_o (evt_level_o),
      .ovf_o       (ovf_o),
      .ovf_clr_i   (ovf_clr_i)
`ifdef SW_DEBOUNCE_TIMESTAMP_EN
      ,
      .evt_ts_o    (evt_ts_o)
`endif
   );

   always #5 clk = ~clk;

   // Returns at the falling edge on which reset is released.
   task automatic do_reset();
      @(negedge clk);
      reset_i     = 1'b1;
      sw_i        = '0;
      evt_ready_i = 1'b0;
      ovf_clr_i   = 1'b0;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (sw_stable_o !== 4'b0000) begin errors++; $display("FAIL reset_stable: got %b expected 0000", sw_stable_o); end
      checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid_o); end
      checks++; if (evt_ch_o !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", evt_ch_o); end
      checks++; if (evt_level_o !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", evt_level_o); end
      checks++; if (ovf_o !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b expected 0000", ovf_o); end
   endtask

   // Edges are counted from the input change: the first edge that samples it is edge 1.
   task automatic test_latency();
      int n = 0;
      do_reset();
      @(negedge clk);
      sw_i[2] = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (sw_stable_o[2] === 1'b1) begin
            n = i;
            break;
         end
      end
      checks++; if (n !== SYNC + DEB) begin errors++; $display("FAIL latency: got %0d edges expected %0d", n, SYNC + DEB); end
      checks++; if (sw_stable_o !== 4'b0100) begin errors++; $display("FAIL latency_other_ch: got %b expected 0100", sw_stable_o); end
      @(posedge clk); #1;
      checks++;
      if (!(evt_valid_o === 1'b1 && evt_ch_o === 2'd2 && evt_level_o === 1'b1)) begin
         errors++; $display("FAIL latency_event: got v=%b ch=%0d lvl=%b expected v=1 ch=2 lvl=1", evt_valid_o, evt_ch_o, evt_level_o);
      end
      @(negedge clk); evt_ready_i = 1'b1;
      @(negedge clk); evt_ready_i = 1'b0;
      checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL latency_single_event: got valid=%b expected 0", evt_valid_o); end
   endtask

   task automatic test_glitch();
      logic bad = 1'b0;
      @(negedge clk);
      sw_i[0] = 1'b1;
      repeat (5) @(negedge clk);
      sw_i[0] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sw_stable_o !== 4'b0100 || evt_valid_o !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL glitch_reject: got disturbance=%b expected 0", bad); end
   endtask

   task automatic test_back_to_back();
      int found = 0;
      do_reset();
      evt_ready_i = 1'b1;
      @(negedge clk);
      sw_i = 4'hF;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (evt_valid_o === 1'b1) begin
            found = 1;
            break;
         end
      end
      checks++; if (found !== 1) begin errors++; $display("FAIL b2b_timeout: got no event expected one within 30 edges"); end
      checks++; if (sw_stable_o !== 4'hF) begin errors++; $display("FAIL b2b_stable: got %h expected f", sw_stable_o); end
      for (int k = 0; k < NCH; k++) begin
         checks++;
         if (!(evt_valid_o === 1'b1 && evt_ch_o === 2'(k) && evt_level_o === 1'b1)) begin
            errors++; $display("FAIL b2b_event%0d: got v=%b ch=%0d lvl=%b expected v=1 ch=%0d lvl=1", k, evt_valid_o, evt_ch_o, evt_level_o, k);
         end
         @(posedge clk); #1;
      end
      checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b expected 0", evt_valid_o); end
   endtask

   task automatic test_overflow();
      do_reset();
      @(negedge clk);
      sw_i[0] = 1'b1;                  // parks a ch0 event in the output register
      repeat (20) @(negedge clk);
      sw_i[1] = 1'b1;
      repeat (20) @(negedge clk);
      sw_i[1] = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (ovf_o !== 4'b0010) begin errors++; $display("FAIL ovf_set: got %b expected 0010", ovf_o); end
      checks++;
      if (!(evt_valid_o === 1'b1 && evt_ch_o === 2'd0 && evt_level_o === 1'b1)) begin
         errors++; $display("FAIL ovf_hold: got v=%b ch=%0d lvl=%b expected v=1 ch=0 lvl=1", evt_valid_o, evt_ch_o, evt_level_o);
      end
      ovf_clr_i = 1'b1;
      @(negedge clk);
      ovf_clr_i = 1'b0;
      checks++; if (ovf_o !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b expected 0000", ovf_o); end
      // Clear pulse aligned with the 10th edge, which commits a second lost change on ch1.
      sw_i[1] = 1'b1;
      repeat (9) @(negedge clk);
      ovf_clr_i = 1'b1;
      @(negedge clk);
      ovf_clr_i = 1'b0;
      checks++; if (ovf_o !== 4'b0010) begin errors++; $display("FAIL ovf_set_wins: got %b expected 0010", ovf_o); end
      checks++; if (sw_stable_o !== 4'b0011) begin errors++; $display("FAIL ovf_stable: got %b expected 0011", sw_stable_o); end
      evt_ready_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (!(evt_valid_o === 1'b1 && evt_ch_o === 2'd1 && evt_level_o === 1'b1)) begin
         errors++; $display("FAIL ovf_latest: got v=%b ch=%0d lvl=%b expected v=1 ch=1 lvl=1", evt_valid_o, evt_ch_o, evt_level_o);
      end
      @(posedge clk); #1;
      checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_single: got valid=%b expected 0", evt_valid_o); end
      @(negedge clk);
      evt_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic bad = 1'b0;
      do_reset();
      @(negedge clk);
      sw_i[0] = 1'b1;
      repeat (15) @(negedge clk);
      checks++; if (evt_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid=%b expected 1", evt_valid_o); end
      sw_i[3] = 1'b1;
      repeat (7) @(posedge clk);      // ch3 counter now reads 5
      #1;
      reset_i = 1'b1;
      sw_i    = '0;
      #1;
      checks++;
      if (!(sw_stable_o === 4'b0000 && evt_valid_o === 1'b0 && evt_ch_o === 2'd0 && evt_level_o === 1'b0 && ovf_o === 4'b0000)) begin
         errors++; $display("FAIL rstmid_immediate: got st=%b v=%b ch=%0d lvl=%b ovf=%b expected all zero", sw_stable_o, evt_valid_o, evt_ch_o, evt_level_o, ovf_o);
      end
      @(negedge clk);
      reset_i     = 1'b0;
      evt_ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (evt_valid_o !== 1'b0 || sw_stable_o !== 4'b0000) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_no_event: got activity=%b expected 0", bad); end
      evt_ready_i = 1'b0;
   endtask

   // Reference: the debouncer sees the raw level SYNC edges late; a level is accepted at the
   // edge where the last DEB seen samples all differ from the accepted level.
   task automatic test_random();
      logic [NCH-1:0] hist[$];
      logic [NCH-1:0] m_stable = '0;
      logic [NCH-1:0] h;
      logic [NCH-1:0] st_bad = '0;
      ev_t            expq[$];
      ev_t            ev;
      int             idx;
      int             n;
      logic           all_diff;
      do_reset();
      evt_ready_i = 1'b1;
      for (int i = 0; i < SYNC + DEB; i++) hist.push_back('0);
      for (int cyc = 0; cyc < 700; cyc++) begin
         @(negedge clk);
         if (evt_valid_o === 1'b1) begin
            idx = -1;
            for (int q = 0; q < expq.size(); q++) begin
               if (idx < 0 && expq[q].ch == evt_ch_o) idx = q;
            end
            checks++;
            if (idx < 0) begin
               errors++; $display("FAIL rand_event: got unexpected event ch=%0d lvl=%b", evt_ch_o, evt_level_o);
            end else begin
               if (expq[idx].lvl !== evt_level_o) begin
                  errors++; $display("FAIL rand_event: got ch=%0d lvl=%b expected lvl=%b", evt_ch_o, evt_level_o, expq[idx].lvl);
               end
               expq.delete(idx);
            end
         end
         if (cyc < 650) begin
            for (int c = 0; c < NCH; c++) begin
               if ($urandom_range(0, 9) == 0) sw_i[c] = ~sw_i[c];
            end
         end
         @(posedge clk);
         hist.push_back(sw_i);
         if (hist.size() > SYNC + DEB + 4) void'(hist.pop_front());
         n = hist.size();
         for (int c = 0; c < NCH; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
               h = hist[n - 1 - SYNC - j];
               if (h[c] == m_stable[c]) all_diff = 1'b0;
            end
            if (all_diff) begin
               m_stable[c] = ~m_stable[c];
               ev.ch  = 2'(c);
               ev.lvl = m_stable[c];
               expq.push_back(ev);
            end
         end
         #1;
         checks++;
         if (sw_stable_o !== m_stable) begin
            errors++;
            if (st_bad == '0) $display("FAIL rand_stable: got %b expected %b at cycle %0d", sw_stable_o, m_stable, cyc);
            st_bad = 4'hF;
         end
      end
      checks++; if (expq.size() != 0) begin errors++; $display("FAIL rand_missing: got %0d undelivered events expected 0", expq.size()); end
      checks++; if (ovf_o !== 4'b0000) begin errors++; $display("FAIL rand_ovf: got %b expected 0000", ovf_o); end
      checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL rand_idle: got valid=%b expected 0", evt_valid_o); end
      evt_ready_i = 1'b0;
   endtask

`ifdef SW_DEBOUNCE_TIMESTAMP_EN
   // Counter reads 0 at the first edge after release; ch2 commits on the 10th edge (counter 9).
   task automatic test_timestamp();
      do_reset();
      sw_i[2] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (!(evt_valid_o === 1'b1 && evt_ch_o === 2'd2 && evt_ts_o === 32'd9)) begin
         errors++; $display("FAIL timestamp: got v=%b ch=%0d ts=%0d expected v=1 ch=2 ts=9", evt_valid_o, evt_ch_o, evt_ts_o);
      end
      evt_ready_i = 1'b1;
      @(negedge clk);
      evt_ready_i = 1'b0;
   endtask
`endif

   initial begin
      reset_i     = 1'b1;
      sw_i        = '0;
      evt_ready_i = 1'b0;
      ovf_clr_i   = 1'b0;
      test_reset();
      test_latency();
      test_glitch();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_random();
`ifdef SW_DEBOUNCE_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
